// File: rtl/mem_pkg.sv
// Shared encodings, response payload and helpers for the request-channel memory controller.
package mem_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam int unsigned ERR_RANGE = 0;
    localparam int unsigned ERR_ALIGN = 1;

    // Payload sized for the widest supported bus; narrower buses leave the top bits zero.
    localparam int unsigned RESP_DATA_W = 64;

    typedef struct packed {
        logic                   we;
        logic [1:0]             err;
        logic [RESP_DATA_W-1:0] rdata;
    } resp_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        logic [3:0] n;
        case (size)
            SZ_B:    n = 4'd1;
            SZ_H:    n = 4'd2;
            SZ_W:    n = 4'd4;
            SZ_D:    n = 4'd8;
            default: n = 4'd8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/resp_fifo.sv
// In-order response queue; head is forced to zero whenever the queue is empty.
module resp_fifo
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push_i,
    input  resp_t data_i,
    input  logic  pop_i,
    output resp_t head_o,
    output logic  full_o,
    output logic  empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    resp_t           mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= ptr_next(wr_ptr_q);
            if (pop_i)  rd_ptr_q <= ptr_next(rd_ptr_q);
            if (push_i && !pop_i)      count_q <= count_q + CW'(1);
            else if (pop_i && !push_i) count_q <= count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_req_ctrl.sv
// Byte-addressable on-chip RAM behind valid/ready request and response channels,
// with a fixed-latency response pipeline, credit-limited outstanding requests and error reporting.
module mem_req_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned RESP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_we,
    output logic [1:0]        resp_err
);

    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = ADDR_W + 1;
    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);

    logic [7:0]             mem_q [DEPTH];
    resp_t                  pipe_q [RD_LAT];
    logic [RD_LAT-1:0]      pipe_vld_q;
    logic [CW-1:0]          outstanding_q;

    logic [3:0]             nbytes_c;
    logic [EW-1:0]          end_c;
    logic [1:0]             err_c;
    logic [NB-1:0]          be_c;
    logic [RESP_DATA_W-1:0] rdata_c;
    logic [AW-1:0]          base_c;
    logic                   accept_c;
    logic                   pop_c;
    resp_t                  stage_c;
    resp_t                  head_c;
    logic                   fifo_full_c;
    logic                   fifo_empty_c;

    assign base_c    = req_addr[AW-1:0];
    assign req_ready = rst && (outstanding_q < CW'(RESP_DEPTH));
    assign accept_c  = req_valid && req_ready;
    assign pop_c     = resp_valid && resp_ready;

    // Decode size/errors and read the addressed bytes; range is checked one bit wider so it cannot wrap.
    always_comb begin
        nbytes_c = size_bytes(req_size);
        end_c    = {1'b0, req_addr} + EW'(nbytes_c);
        err_c    = '0;
        be_c     = '0;
        rdata_c  = '0;
        err_c[ERR_RANGE] = (end_c > EW'(DEPTH));
        err_c[ERR_ALIGN] = (nbytes_c > 4'(NB)) ||
                           ((req_addr[2:0] & 3'(nbytes_c - 4'd1)) != 3'd0);
        for (int i = 0; i < int'(NB); i++) begin
            be_c[i] = (4'(i) < nbytes_c);
            if (be_c[i] && !req_we && (err_c == 2'b00)) begin
                rdata_c[8*i +: 8] = mem_q[base_c + AW'(i)];
            end
        end
        stage_c.we    = req_we;
        stage_c.err   = err_c;
        stage_c.rdata = rdata_c;
    end

    always_ff @(posedge clk) begin
        if (accept_c && req_we && (err_c == 2'b00)) begin
            for (int i = 0; i < int'(NB); i++) begin
                if (be_c[i]) mem_q[base_c + AW'(i)] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Every accepted request, including writes and errors, shifts through all RD_LAT stages.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) pipe_q[i] <= '0;
        end else begin
            pipe_vld_q[0] <= accept_c;
            pipe_q[0]     <= stage_c;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_q[i]     <= pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding_q <= '0;
        end else if (accept_c && !pop_c) begin
            outstanding_q <= outstanding_q + CW'(1);
        end else if (pop_c && !accept_c) begin
            outstanding_q <= outstanding_q - CW'(1);
        end
    end

    resp_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (pipe_vld_q[RD_LAT-1] && !fifo_full_c),
        .data_i  (pipe_q[RD_LAT-1]),
        .pop_i   (pop_c),
        .head_o  (head_c),
        .full_o  (fifo_full_c),
        .empty_o (fifo_empty_c)
    );

    assign resp_valid = !fifo_empty_c;
    assign resp_rdata = head_c.rdata[DATA_W-1:0];
    assign resp_we    = head_c.we;
    assign resp_err   = head_c.err;

    generate
        if (DATA_W < RESP_DATA_W) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^head_c.rdata[RESP_DATA_W-1:DATA_W];
        end
    endgenerate

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed and random checks of mem_req_ctrl against a byte-array model with an in-order response queue.
module tb_mem_req_ctrl;
    import mem_pkg::*;

    localparam int unsigned DEPTH      = 1024;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned ADDR_W     = 64;
    localparam int unsigned RD_LAT     = 3;
    localparam int unsigned RESP_DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_we;
    logic [1:0]        resp_err;

    always #5 clk = ~clk;

    mem_req_ctrl #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT), .RESP_DEPTH(RESP_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_we(resp_we), .resp_err(resp_err)
    );

    typedef struct {
        logic        we;
        logic [1:0]  err;
        logic [63:0] rdata;
        int unsigned k;
    } exp_t;

    exp_t        eq[$];
    logic [7:0]  ref_mem [DEPTH];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    int unsigned cyc = 0;
    int unsigned last_k = 0;
    int unsigned s_cyc = 0;
    logic        s_valid, s_acc, s_pop, s_we;
    logic [63:0] s_rdata;
    logic [1:0]  s_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte array updated at acceptance, response queued with its acceptance edge.
    task automatic model(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata, input int unsigned k);
        exp_t        e;
        int unsigned nb;
        logic [64:0] sum;
        int          base;
        nb    = 32'd1 << size;
        sum   = {1'b0, addr} + 65'(nb);
        e.we  = we;
        e.k   = k;
        e.rdata = '0;
        e.err = '0;
        e.err[ERR_ALIGN] = (nb > DATA_W / 8) || ((addr % 64'(nb)) != 64'd0);
        e.err[ERR_RANGE] = (sum > 65'(DEPTH));
        if (e.err == 2'b00) begin
            base = int'(addr % 64'(DEPTH));
            for (int i = 0; i < int'(nb); i++) begin
                if (we) ref_mem[base + i] = wdata[8*i +: 8];
                else    e.rdata[8*i +: 8] = ref_mem[base + i];
            end
        end
        eq.push_back(e);
    endtask

    // One clock: check outputs at the falling edge, then account for handshakes at the rising edge.
    task automatic step();
        logic exp_v;
        @(negedge clk);
        s_cyc = cyc;
        chk("req_ready", 64'(req_ready), 64'(rst && (eq.size() < int'(RESP_DEPTH))));
        exp_v = 1'b0;
        if (eq.size() != 0) exp_v = (cyc >= eq[0].k + RD_LAT);
        chk("resp_valid", 64'(resp_valid), 64'(exp_v));
        if (resp_valid && (eq.size() != 0)) begin
            chk("resp_rdata", resp_rdata, eq[0].rdata);
            chk("resp_we", 64'(resp_we), 64'(eq[0].we));
            chk("resp_err", 64'(resp_err), 64'(eq[0].err));
        end
        s_valid = resp_valid;
        s_rdata = resp_rdata;
        s_we    = resp_we;
        s_err   = resp_err;
        s_acc   = req_valid && req_ready;
        s_pop   = resp_valid && resp_ready;
        @(posedge clk);
        cyc++;
        if (s_pop && (eq.size() != 0)) void'(eq.pop_front());
        if (s_acc) begin
            model(req_we, req_size, req_addr, req_wdata, cyc);
            last_k = cyc;
        end
        #1;
    endtask

    task automatic set_req(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata);
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic [63:0] addr,
                         input logic [63:0] wdata);
        set_req(we, size, addr, wdata);
        req_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            step();
            if (s_acc) break;
        end
        chk("issue_accept", 64'(s_acc), 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string tag, input logic [63:0] exp_rdata,
                             input logic [1:0] exp_err, input bit chk_lat);
        for (int n = 0; n < 50; n++) begin
            step();
            if (s_pop) break;
        end
        chk({tag, "_seen"}, 64'(s_pop), 64'd1);
        chk({tag, "_rdata"}, s_rdata, exp_rdata);
        chk({tag, "_err"}, 64'(s_err), 64'(exp_err));
        if (chk_lat) chk({tag, "_latency"}, 64'(s_cyc - last_k), 64'(RD_LAT));
    endtask

    // mode 0: random mix incl. errors; mode 1: fill array with doublewords; mode 2: doubleword reads.
    task automatic gen(input int mode, input int idx);
        logic [1:0]  sz;
        logic [63:0] a;
        int unsigned r;
        case (mode)
            1: set_req(1'b1, SZ_D, 64'(idx * 8), {$urandom, $urandom});
            2: set_req(1'b0, SZ_D, 64'(256 + idx * 8), 64'd0);
            default: begin
                r  = $urandom_range(0, 15);
                sz = 2'($urandom_range(0, 3));
                a  = 64'($urandom_range(0, DEPTH - 1)) & ~((64'd1 << sz) - 64'd1);
                if (r == 0) a = a + 64'd1;
                if (r == 1) a = 64'(DEPTH) + 64'($urandom_range(0, 64));
                if (r == 2) a = 64'hFFFF_FFFF_FFFF_FFF8;
                set_req(1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom});
            end
        endcase
    endtask

    task automatic stream(input int mode, input int n);
        int idx = 0;
        gen(mode, 0);
        for (int c = 0; (c < 20 * n + 100) && ((idx < n) || (eq.size() != 0)); c++) begin
            req_valid = (idx < n);
            step();
            if (s_acc) begin
                idx++;
                if (idx < n) gen(mode, idx);
            end
        end
        req_valid = 1'b0;
        chk("stream_count", 64'(idx), 64'(n));
        chk("stream_drained", 64'(eq.size()), 64'd0);
    endtask

    initial begin
        int idx;
        rst        = 1'b0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        set_req(1'b0, SZ_B, 64'd0, 64'd0);

        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_we", 64'(resp_we), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        stream(1, DEPTH / 8);

        issue(1'b1, SZ_D, 64'h10, 64'h1122_3344_5566_7788);
        wait_resp("wr_d", 64'd0, 2'b00, 1'b1);
        issue(1'b0, SZ_D, 64'h10, 64'd0);
        wait_resp("rd_d", 64'h1122_3344_5566_7788, 2'b00, 1'b1);

        issue(1'b1, SZ_B, 64'h13, 64'hAA);
        wait_resp("wr_b", 64'd0, 2'b00, 1'b0);
        issue(1'b0, SZ_W, 64'h10, 64'd0);
        wait_resp("rd_w", 64'h0000_0000_AA66_7788, 2'b00, 1'b0);
        issue(1'b0, SZ_H, 64'h12, 64'd0);
        wait_resp("rd_h", 64'h0000_0000_0000_AA66, 2'b00, 1'b0);

        issue(1'b0, SZ_W, 64'h6, 64'd0);
        wait_resp("err_align", 64'd0, 2'b10, 1'b0);
        issue(1'b1, SZ_D, 64'(DEPTH - 8), 64'h0123_4567_89AB_CDEF);
        wait_resp("wr_top", 64'd0, 2'b00, 1'b0);
        issue(1'b0, SZ_D, 64'(DEPTH - 8), 64'd0);
        wait_resp("rd_top", 64'h0123_4567_89AB_CDEF, 2'b00, 1'b0);
        issue(1'b1, SZ_W, 64'(DEPTH - 4), 64'hCAFE_F00D);
        wait_resp("wr_last_w", 64'd0, 2'b00, 1'b0);
        issue(1'b1, SZ_D, 64'(DEPTH - 4), 64'hFFFF_FFFF_FFFF_FFFF);
        wait_resp("err_both", 64'd0, 2'b11, 1'b0);
        issue(1'b0, SZ_W, 64'(DEPTH - 4), 64'd0);
        wait_resp("rd_unchanged", 64'hCAFE_F00D, 2'b00, 1'b0);
        issue(1'b0, SZ_B, 64'(DEPTH), 64'd0);
        wait_resp("err_range", 64'd0, 2'b01, 1'b0);
        issue(1'b0, SZ_D, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
        wait_resp("err_nowrap", 64'd0, 2'b01, 1'b0);

        resp_ready = 1'b0;
        idx = 0;
        gen(2, 0);
        for (int c = 0; c < 12; c++) begin
            req_valid = (idx < 6);
            step();
            if (s_acc) begin
                idx++;
                gen(2, idx);
            end
        end
        chk("bp_accepted", 64'(idx), 64'd4);
        chk("bp_req_ready", 64'(req_ready), 64'd0);
        resp_ready = 1'b1;
        for (int c = 0; (c < 60) && ((idx < 6) || (eq.size() != 0)); c++) begin
            req_valid = (idx < 6);
            step();
            if (s_acc) begin
                idx++;
                gen(2, idx);
            end
        end
        req_valid = 1'b0;
        chk("bp_total", 64'(idx), 64'd6);
        chk("bp_drained", 64'(eq.size()), 64'd0);

        issue(1'b1, SZ_D, 64'h40, 64'hDEAD_BEEF_0BAD_F00D);
        wait_resp("pre_rst_wr", 64'd0, 2'b00, 1'b0);
        resp_ready = 1'b0;
        issue(1'b1, SZ_D, 64'h48, 64'h0102_0304_0506_0708);
        issue(1'b0, SZ_D, 64'h40, 64'd0);
        issue(1'b0, SZ_D, 64'h48, 64'd0);
        chk("mid_outstanding", 64'(eq.size()), 64'd3);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_resp_err", 64'(resp_err), 64'd0);
        eq.delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        resp_ready = 1'b1;
        for (int c = 0; c < 8; c++) step();
        issue(1'b0, SZ_D, 64'h40, 64'd0);
        wait_resp("post_rst_rd40", 64'hDEAD_BEEF_0BAD_F00D, 2'b00, 1'b1);
        issue(1'b0, SZ_D, 64'h48, 64'd0);
        wait_resp("post_rst_rd48", 64'h0102_0304_0506_0708, 2'b00, 1'b0);

        stream(0, 100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
